// File: rtl/tx_link_ctrl.sv
// Per-lane TX link-layer sequencer: frame/LMFC counters, SYNC~ handling, CGS -> ILA -> DATA
// sequencing with SYNC~-low resync and the lane output mux select.
module tx_link_ctrl #(
   parameter int unsigned RESYNC_EXTRA = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_en,
   input  logic       i_sync_n,
   input  logic [7:0] i_F,
   input  logic [4:0] i_K,
   input  logic       i_ila_seq_end,
   output logic       o_seq_start,
   output logic [4:0] o_no_frame_de_assertion,
   output logic [1:0] o_sel,
   output logic       o_lmfc,
   output logic       o_link_up,
   output logic       o_resync
);

   typedef enum logic [1:0] {
      ST_CGS  = 2'd0,
      ST_ILA  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  oct_cnt_q, oct_cnt_d;
   logic [4:0]  frm_cnt_q, frm_cnt_d;
   logic [10:0] low_cnt_q, low_cnt_d;
   logic        pend_q, pend_d;
   logic        sync_d_q;
   logic [4:0]  nfd_q, nfd_d;
   logic        seq_start_q, seq_start_d;
   logic        resync_q, resync_d;
   logic        lmfc_q, lmfc_d;
   logic [1:0]  sel_q, sel_d;
   logic        link_up_q, link_up_d;

   logic [10:0] thr;
   logic [10:0] low_inc;
   logic        mf_last;
   logic        sync_rise;
   logic        resync_hit;

   always_comb begin
      oct_cnt_d = oct_cnt_q + 8'd1;
      frm_cnt_d = frm_cnt_q;
      // >= rather than == so a reduced i_F / i_K still wraps immediately
      if (oct_cnt_q >= i_F) begin
         oct_cnt_d = 8'd0;
         frm_cnt_d = (frm_cnt_q >= i_K) ? 5'd0 : frm_cnt_q + 5'd1;
      end
      lmfc_d = (oct_cnt_q == 8'd0) && (frm_cnt_q == 5'd0);

      thr        = 11'd5 * ({3'b000, i_F} + 11'd1) + 11'(RESYNC_EXTRA);
      low_inc    = low_cnt_q + 11'd1;
      mf_last    = (oct_cnt_q == i_F) && (frm_cnt_q == i_K);
      sync_rise  = !sync_d_q && i_sync_n;
      resync_hit = !i_sync_n && (low_inc >= thr);

      state_d     = state_q;
      pend_d      = pend_q;
      low_cnt_d   = low_cnt_q;
      nfd_d       = nfd_q;
      seq_start_d = 1'b0;
      resync_d    = 1'b0;

      if (!i_en) begin
         state_d   = ST_CGS;
         pend_d    = 1'b0;
         low_cnt_d = 11'd0;
      end else begin
         case (state_q)
            ST_CGS: begin
               low_cnt_d = 11'd0;
               if (sync_rise) begin
                  nfd_d  = frm_cnt_q;
                  pend_d = 1'b1;
               end
               if (!i_sync_n) pend_d = 1'b0;
               // ILA must begin on the first octet of a multiframe
               if (pend_q && mf_last && i_sync_n) begin
                  seq_start_d = 1'b1;
                  state_d     = ST_ILA;
                  pend_d      = 1'b0;
               end
            end
            ST_ILA, ST_DATA: begin
               pend_d = 1'b0;
               if (i_sync_n) begin
                  low_cnt_d = 11'd0;
               end else if (resync_hit) begin
                  low_cnt_d = 11'd0;
               end else begin
                  low_cnt_d = low_inc;
               end
               if (resync_hit) begin
                  state_d  = ST_CGS;
                  resync_d = 1'b1;
               end else if (state_q == ST_ILA && i_ila_seq_end) begin
                  state_d = ST_DATA;
               end
            end
            default: begin
               state_d   = ST_CGS;
               pend_d    = 1'b0;
               low_cnt_d = 11'd0;
            end
         endcase
      end

      // Mux select and link-up follow the registered state one cycle later
      case (state_q)
         ST_ILA:  sel_d = 2'd1;
         ST_DATA: sel_d = 2'd2;
         default: sel_d = 2'd0;
      endcase
      link_up_d = (state_q == ST_DATA);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_CGS;
         oct_cnt_q   <= 8'd0;
         frm_cnt_q   <= 5'd0;
         low_cnt_q   <= 11'd0;
         pend_q      <= 1'b0;
         sync_d_q    <= 1'b1;
         nfd_q       <= 5'd0;
         seq_start_q <= 1'b0;
         resync_q    <= 1'b0;
         lmfc_q      <= 1'b0;
         sel_q       <= 2'd0;
         link_up_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         oct_cnt_q   <= oct_cnt_d;
         frm_cnt_q   <= frm_cnt_d;
         low_cnt_q   <= low_cnt_d;
         pend_q      <= pend_d;
         sync_d_q    <= i_sync_n;
         nfd_q       <= nfd_d;
         seq_start_q <= seq_start_d;
         resync_q    <= resync_d;
         lmfc_q      <= lmfc_d;
         sel_q       <= sel_d;
         link_up_q   <= link_up_d;
      end
   end

   assign o_seq_start             = seq_start_q;
   assign o_no_frame_de_assertion = nfd_q;
   assign o_sel                   = sel_q;
   assign o_lmfc                  = lmfc_q;
   assign o_link_up               = link_up_q;
   assign o_resync                = resync_q;

endmodule

// File: tb/tb_tx_link_ctrl.sv
// Directed self-checking bench for tx_link_ctrl with i_F=1, i_K=3 (8 octets per multiframe).
module tb_tx_link_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_en;
   logic       i_sync_n;
   logic [7:0] i_F;
   logic [4:0] i_K;
   logic       i_ila_seq_end;
   logic       o_seq_start;
   logic [4:0] o_no_frame_de_assertion;
   logic [1:0] o_sel;
   logic       o_lmfc;
   logic       o_link_up;
   logic       o_resync;

   int checks = 0;
   int fails  = 0;
   // Counter position (frm*2+oct) the DUT holds after the most recent edge
   int pos    = 0;

   tx_link_ctrl #(.RESYNC_EXTRA(9)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .i_en                    (i_en),
      .i_sync_n                (i_sync_n),
      .i_F                     (i_F),
      .i_K                     (i_K),
      .i_ila_seq_end           (i_ila_seq_end),
      .o_seq_start             (o_seq_start),
      .o_no_frame_de_assertion (o_no_frame_de_assertion),
      .o_sel                   (o_sel),
      .o_lmfc                  (o_lmfc),
      .o_link_up               (o_link_up),
      .o_resync                (o_resync)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      if (rst) pos = 0;
      else     pos = (pos + 1) % 8;
   endtask

   task automatic test_reset();
      rst = 1'b1; i_en = 1'b0; i_sync_n = 1'b0; i_ila_seq_end = 1'b0;
      i_F = 8'd1; i_K = 5'd3;
      tick(); tick();
      checks++; if (o_sel !== 2'd0) begin fails++; $display("[TB] FAIL reset_sel got %0d want 0", o_sel); end
      checks++; if (o_link_up !== 1'b0) begin fails++; $display("[TB] FAIL reset_link_up got %0b want 0", o_link_up); end
      checks++; if (o_lmfc !== 1'b0) begin fails++; $display("[TB] FAIL reset_lmfc got %0b want 0", o_lmfc); end
      checks++; if (o_seq_start !== 1'b0) begin fails++; $display("[TB] FAIL reset_seq_start got %0b want 0", o_seq_start); end
      checks++; if (o_resync !== 1'b0) begin fails++; $display("[TB] FAIL reset_resync got %0b want 0", o_resync); end
      checks++; if (o_no_frame_de_assertion !== 5'd0) begin fails++; $display("[TB] FAIL reset_nfd got %0d want 0", o_no_frame_de_assertion); end
   endtask

   task automatic test_lmfc();
      rst = 1'b0; i_en = 1'b1;
      for (int i = 0; i < 17; i++) begin
         tick();
         checks++;
         if (o_lmfc !== (pos == 1)) begin
            fails++; $display("[TB] FAIL lmfc cycle %0d got %0b want %0b", i, o_lmfc, (pos == 1));
         end
      end
   endtask

   task automatic test_sync_capture();
      while (pos != 4) tick();
      i_sync_n = 1'b1;
      tick();
      checks++; if (o_no_frame_de_assertion !== 5'd2) begin fails++; $display("[TB] FAIL capture_nfd got %0d want 2", o_no_frame_de_assertion); end
      tick(); tick();
      checks++; if (o_seq_start !== 1'b0) begin fails++; $display("[TB] FAIL seq_start_early got %0b want 0", o_seq_start); end
      tick();
      checks++; if (o_seq_start !== 1'b1) begin fails++; $display("[TB] FAIL seq_start_boundary got %0b want 1", o_seq_start); end
      checks++; if (o_sel !== 2'd0) begin fails++; $display("[TB] FAIL sel_lag got %0d want 0", o_sel); end
      tick();
      checks++; if (o_seq_start !== 1'b0) begin fails++; $display("[TB] FAIL seq_start_width got %0b want 0", o_seq_start); end
      checks++; if (o_sel !== 2'd1) begin fails++; $display("[TB] FAIL sel_ila got %0d want 1", o_sel); end
      checks++; if (o_link_up !== 1'b0) begin fails++; $display("[TB] FAIL ila_link_up got %0b want 0", o_link_up); end
   endtask

   task automatic test_ila_to_data();
      tick(); tick();
      checks++; if (o_sel !== 2'd1) begin fails++; $display("[TB] FAIL ila_hold got %0d want 1", o_sel); end
      i_ila_seq_end = 1'b1;
      tick();
      i_ila_seq_end = 1'b0;
      tick();
      checks++; if (o_sel !== 2'd2) begin fails++; $display("[TB] FAIL sel_data got %0d want 2", o_sel); end
      checks++; if (o_link_up !== 1'b1) begin fails++; $display("[TB] FAIL data_link_up got %0b want 1", o_link_up); end
   endtask

   task automatic test_resync();
      i_sync_n = 1'b0;
      for (int i = 0; i < 18; i++) begin
         tick();
         checks++; if (o_resync !== 1'b0) begin fails++; $display("[TB] FAIL resync_short cycle %0d got %0b want 0", i, o_resync); end
      end
      i_sync_n = 1'b1;
      tick(); tick();
      checks++; if (o_sel !== 2'd2) begin fails++; $display("[TB] FAIL short_low_sel got %0d want 2", o_sel); end
      i_sync_n = 1'b0;
      for (int i = 0; i < 18; i++) tick();
      checks++; if (o_resync !== 1'b0) begin fails++; $display("[TB] FAIL resync_18 got %0b want 0", o_resync); end
      tick();
      checks++; if (o_resync !== 1'b1) begin fails++; $display("[TB] FAIL resync_19 got %0b want 1", o_resync); end
      tick();
      checks++; if (o_resync !== 1'b0) begin fails++; $display("[TB] FAIL resync_width got %0b want 0", o_resync); end
      checks++; if (o_sel !== 2'd0) begin fails++; $display("[TB] FAIL resync_sel got %0d want 0", o_sel); end
      checks++; if (o_link_up !== 1'b0) begin fails++; $display("[TB] FAIL resync_link_up got %0b want 0", o_link_up); end
   endtask

   task automatic test_ila_end_in_cgs();
      i_ila_seq_end = 1'b1;
      tick();
      i_ila_seq_end = 1'b0;
      tick(); tick();
      checks++; if (o_sel !== 2'd0) begin fails++; $display("[TB] FAIL cgs_ila_end_sel got %0d want 0", o_sel); end
      checks++; if (o_link_up !== 1'b0) begin fails++; $display("[TB] FAIL cgs_ila_end_link got %0b want 0", o_link_up); end
   endtask

   task automatic test_cancel();
      while (pos != 0) tick();
      i_sync_n = 1'b1;
      tick(); tick(); tick();
      i_sync_n = 1'b0;
      checks++; if (o_no_frame_de_assertion !== 5'd0) begin fails++; $display("[TB] FAIL cancel_nfd got %0d want 0", o_no_frame_de_assertion); end
      for (int i = 0; i < 16; i++) begin
         tick();
         checks++; if (o_seq_start !== 1'b0) begin fails++; $display("[TB] FAIL cancel_seq_start cycle %0d got %0b want 0", i, o_seq_start); end
      end
      checks++; if (o_sel !== 2'd0) begin fails++; $display("[TB] FAIL cancel_sel got %0d want 0", o_sel); end
   endtask

   task automatic goto_data();
      int n;
      n = 0;
      i_sync_n = 1'b1;
      tick();
      while (o_seq_start !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++; if (n >= 20) begin fails++; $display("[TB] FAIL goto_data_timeout got no seq_start want pulse"); end
      tick();
      i_ila_seq_end = 1'b1;
      tick();
      i_ila_seq_end = 1'b0;
      tick();
      checks++; if (o_link_up !== 1'b1) begin fails++; $display("[TB] FAIL goto_data_link got %0b want 1", o_link_up); end
   endtask

   task automatic test_priority();
      goto_data();
      i_sync_n = 1'b0;
      for (int i = 0; i < 18; i++) tick();
      i_en = 1'b0;
      tick();
      checks++; if (o_resync !== 1'b0) begin fails++; $display("[TB] FAIL priority_resync got %0b want 0", o_resync); end
      i_en = 1'b1;
      tick();
      checks++; if (o_sel !== 2'd0) begin fails++; $display("[TB] FAIL priority_sel got %0d want 0", o_sel); end
      checks++; if (o_resync !== 1'b0) begin fails++; $display("[TB] FAIL priority_resync_late got %0b want 0", o_resync); end
   endtask

   task automatic test_reset_in_data();
      goto_data();
      rst = 1'b1;
      tick();
      checks++; if (o_sel !== 2'd0) begin fails++; $display("[TB] FAIL rst_data_sel got %0d want 0", o_sel); end
      checks++; if (o_link_up !== 1'b0) begin fails++; $display("[TB] FAIL rst_data_link got %0b want 0", o_link_up); end
      checks++; if (o_no_frame_de_assertion !== 5'd0) begin fails++; $display("[TB] FAIL rst_data_nfd got %0d want 0", o_no_frame_de_assertion); end
      checks++; if (o_lmfc !== 1'b0) begin fails++; $display("[TB] FAIL rst_data_lmfc got %0b want 0", o_lmfc); end
      rst = 1'b0;
      tick();
      checks++; if (o_lmfc !== 1'b1) begin fails++; $display("[TB] FAIL rst_data_first_lmfc got %0b want 1", o_lmfc); end
   endtask

   initial begin
      test_reset();
      test_lmfc();
      test_sync_capture();
      test_ila_to_data();
      test_resync();
      test_ila_end_in_cgs();
      test_cancel();
      test_priority();
      test_reset_in_data();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
